// File: rtl/redmule_pkg.sv
// Shared constants and types for the RedMulE configuration target.
// Holds the register map offsets and the configuration-slave FSM state type.
package redmule_pkg;

  localparam logic [7:0] REDMULE_TRIGGER_OFFS = 8'h00;
  localparam logic [7:0] REDMULE_STATUS_OFFS  = 8'h04;
  localparam logic [7:0] REDMULE_CFG_BASE     = 8'h40;

  typedef enum logic [1:0] {
    Idle       = 2'd0,
    Run        = 2'd1,
    RunPending = 2'd2
  } redmule_cfg_slave_state_e;

endpackage

// File: rtl/hwpe_ctrl_intf_periph.sv
// Peripheral register-access interface between a control master and a target.
// Signals:
//   req/add/wen/be/data/id  : request from the master (wen=1 read, wen=0 write)
//   gnt                     : same-cycle grant from the target
//   r_data/r_valid/r_id     : response one cycle after each grant
interface hwpe_ctrl_intf_periph #(
  parameter int unsigned ID_WIDTH = 8
);
  logic                req;
  logic                gnt;
  logic [31:0]         add;
  logic                wen;
  logic [3:0]          be;
  logic [31:0]         data;
  logic [ID_WIDTH-1:0] id;
  logic [31:0]         r_data;
  logic                r_valid;
  logic [ID_WIDTH-1:0] r_id;

  modport master (
    output req, add, wen, be, data, id,
    input  gnt, r_data, r_valid, r_id
  );

  modport slave (
    input  req, add, wen, be, data, id,
    output gnt, r_data, r_valid, r_id
  );
endinterface

// File: rtl/redmule_cfg_bank.sv
// Register array of NumRegs words of DataWidth bits.
// Ports:
//   clk_i, rst_ni, clear_i        : clock, async active-low reset, sync clear
//   we_i/waddr_i/wdata_i/be_i     : byte-enable write port
//   raddr_i/rdata_o               : combinational read port (0 when out of range)
//   load_i/load_data_i            : parallel load of the whole bank (wins over we_i)
//   dump_o                        : whole bank, word i at bits [i*DataWidth +: DataWidth]
module redmule_cfg_bank #(
  parameter int unsigned NumRegs   = 6,
  parameter int unsigned DataWidth = 32,
  localparam int unsigned IdxW     = (NumRegs > 1) ? $clog2(NumRegs) : 1,
  localparam int unsigned BeW      = DataWidth / 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         we_i,
  input  logic [IdxW-1:0]              waddr_i,
  input  logic [DataWidth-1:0]         wdata_i,
  input  logic [BeW-1:0]               be_i,
  input  logic [IdxW-1:0]              raddr_i,
  output logic [DataWidth-1:0]         rdata_o,
  input  logic                         load_i,
  input  logic [NumRegs*DataWidth-1:0] load_data_i,
  output logic [NumRegs*DataWidth-1:0] dump_o
);

  logic [DataWidth-1:0] regs_r [NumRegs];

  // Bank storage: reset/clear, whole-bank load, or byte-masked word write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumRegs; i++) regs_r[i] <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < NumRegs; i++) regs_r[i] <= '0;
    end else if (load_i) begin
      for (int i = 0; i < NumRegs; i++) regs_r[i] <= load_data_i[i*DataWidth +: DataWidth];
    end else if (we_i && (32'(waddr_i) < NumRegs)) begin
      for (int b = 0; b < BeW; b++) begin
        if (be_i[b]) regs_r[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = (32'(raddr_i) < NumRegs) ? regs_r[raddr_i] : '0;

  for (genvar g = 0; g < NumRegs; g++) begin : g_dump
    assign dump_o[g*DataWidth +: DataWidth] = regs_r[g];
  end

endmodule

// File: rtl/redmule_cfg_slave.sv
// Configuration target for the RedMulE engine.
// Captures config words into a shadow bank, accepts trigger writes and promotes
// the shadow bank to the active bank (one job may wait in a pending bank).
// Ports:
//   clk_i, rst_ni, clear_i : clock, async active-low reset, sync clear
//   periph                 : register access target (gnt combinational, response registered)
//   engine_done_i          : pulse when the active job finishes
//   cfg_o                  : active config bank
//   start_o                : pulse, active bank holds a new job this cycle
//   busy_o                 : engine owns the active bank
//   cfg_complete_o         : a trigger write would be granted this cycle
module redmule_cfg_slave
  import redmule_pkg::*;
#(
  parameter int unsigned SysDataWidth = 32,
  parameter int unsigned NumCfgRegs   = 6,
  parameter logic [7:0]  CfgBase      = REDMULE_CFG_BASE,
  parameter int unsigned IdWidth      = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             clear_i,
  hwpe_ctrl_intf_periph.slave              periph,
  input  logic                             engine_done_i,
  output logic [NumCfgRegs*SysDataWidth-1:0] cfg_o,
  output logic                             start_o,
  output logic                             busy_o,
  output logic                             cfg_complete_o
);

  localparam int unsigned IdxW    = (NumCfgRegs > 1) ? $clog2(NumCfgRegs) : 1;
  localparam logic [5:0]  CfgWord = CfgBase[7:2];
  localparam logic [5:0]  TrigWord = REDMULE_TRIGGER_OFFS[7:2];
  localparam logic [5:0]  StatWord = REDMULE_STATUS_OFFS[7:2];

  redmule_cfg_slave_state_e state_r, state_n;

  logic [5:0]              word_s, cfg_off_s;
  logic [IdxW-1:0]         cfg_idx_s;
  logic                    is_trig_s, is_stat_s, is_cfg_s;
  logic                    wr_s, stall_s, gnt_s, trig_s, shadow_we_s;
  logic                    start_s, load_pend_s, load_act_s, act_from_pend_s;
  logic [SysDataWidth-1:0] shadow_rdata_s, rdata_s;
  logic [SysDataWidth-1:0] unused_pend_rdata, unused_act_rdata;
  logic [NumCfgRegs*SysDataWidth-1:0] shadow_dump_s, pend_dump_s;
  logic                    r_valid_r, start_r;
  logic [SysDataWidth-1:0] r_data_r;
  logic [IdWidth-1:0]      r_id_r;

  // Address decode on the word offset; byte bits and upper address bits are ignored.
  assign word_s    = periph.add[7:2];
  assign cfg_off_s = word_s - CfgWord;
  assign cfg_idx_s = cfg_off_s[IdxW-1:0];
  assign is_trig_s = (word_s == TrigWord);
  assign is_stat_s = (word_s == StatWord);
  assign is_cfg_s  = (word_s >= CfgWord) && ({26'd0, cfg_off_s} < NumCfgRegs);

  assign wr_s        = ~periph.wen;
  // Only a trigger with the single queue slot already taken is held off.
  assign stall_s     = periph.req & wr_s & is_trig_s & (state_r == RunPending);
  assign gnt_s       = periph.req & ~stall_s;
  assign trig_s      = gnt_s & wr_s & is_trig_s;
  assign shadow_we_s = gnt_s & wr_s & is_cfg_s;

  // Next-state and bank-transfer decisions.
  always_comb begin
    state_n         = state_r;
    start_s         = 1'b0;
    load_pend_s     = 1'b0;
    load_act_s      = 1'b0;
    act_from_pend_s = 1'b0;
    case (state_r)
      Idle: begin
        if (trig_s) begin
          load_act_s = 1'b1;
          start_s    = 1'b1;
          state_n    = Run;
        end else begin
          state_n = Idle;
        end
      end
      Run: begin
        if (trig_s && engine_done_i) begin
          // Slot frees as the new job arrives: skip the pending bank.
          load_act_s = 1'b1;
          start_s    = 1'b1;
          state_n    = Run;
        end else if (trig_s) begin
          load_pend_s = 1'b1;
          state_n     = RunPending;
        end else if (engine_done_i) begin
          state_n = Idle;
        end else begin
          state_n = Run;
        end
      end
      RunPending: begin
        if (engine_done_i) begin
          load_act_s      = 1'b1;
          act_from_pend_s = 1'b1;
          start_s         = 1'b1;
          state_n         = Run;
        end else begin
          state_n = RunPending;
        end
      end
      default: begin
        state_n = Idle;
      end
    endcase
  end

  // Read value for the addressed register; unmapped and write-only words read 0.
  always_comb begin
    rdata_s = '0;
    if (is_stat_s) begin
      rdata_s = {{(SysDataWidth-2){1'b0}}, (state_r == RunPending), (state_r != Idle)};
    end else if (is_cfg_s) begin
      rdata_s = shadow_rdata_s;
    end else begin
      rdata_s = '0;
    end
  end

  // FSM state and start pulse register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= Idle;
      start_r <= 1'b0;
    end else if (clear_i) begin
      state_r <= Idle;
      start_r <= 1'b0;
    end else begin
      state_r <= state_n;
      start_r <= start_s;
    end
  end

  // Registered response: one cycle after every granted request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_r <= 1'b0;
      r_data_r  <= '0;
      r_id_r    <= '0;
    end else if (clear_i) begin
      r_valid_r <= 1'b0;
      r_data_r  <= '0;
      r_id_r    <= '0;
    end else begin
      r_valid_r <= gnt_s;
      r_data_r  <= (gnt_s && periph.wen) ? rdata_s : '0;
      r_id_r    <= gnt_s ? periph.id : '0;
    end
  end

  redmule_cfg_bank #(.NumRegs(NumCfgRegs), .DataWidth(SysDataWidth)) i_shadow (
    .clk_i, .rst_ni, .clear_i,
    .we_i        (shadow_we_s),
    .waddr_i     (cfg_idx_s),
    .wdata_i     (periph.data),
    .be_i        (periph.be),
    .raddr_i     (cfg_idx_s),
    .rdata_o     (shadow_rdata_s),
    .load_i      (1'b0),
    .load_data_i ({(NumCfgRegs*SysDataWidth){1'b0}}),
    .dump_o      (shadow_dump_s)
  );

  redmule_cfg_bank #(.NumRegs(NumCfgRegs), .DataWidth(SysDataWidth)) i_pending (
    .clk_i, .rst_ni, .clear_i,
    .we_i        (1'b0),
    .waddr_i     ({IdxW{1'b0}}),
    .wdata_i     ({SysDataWidth{1'b0}}),
    .be_i        ({(SysDataWidth/8){1'b0}}),
    .raddr_i     ({IdxW{1'b0}}),
    .rdata_o     (unused_pend_rdata),
    .load_i      (load_pend_s),
    .load_data_i (shadow_dump_s),
    .dump_o      (pend_dump_s)
  );

  redmule_cfg_bank #(.NumRegs(NumCfgRegs), .DataWidth(SysDataWidth)) i_active (
    .clk_i, .rst_ni, .clear_i,
    .we_i        (1'b0),
    .waddr_i     ({IdxW{1'b0}}),
    .wdata_i     ({SysDataWidth{1'b0}}),
    .be_i        ({(SysDataWidth/8){1'b0}}),
    .raddr_i     ({IdxW{1'b0}}),
    .rdata_o     (unused_act_rdata),
    .load_i      (load_act_s),
    .load_data_i (act_from_pend_s ? pend_dump_s : shadow_dump_s),
    .dump_o      (cfg_o)
  );

  assign periph.gnt     = gnt_s;
  assign periph.r_valid = r_valid_r;
  assign periph.r_data  = r_data_r;
  assign periph.r_id    = r_id_r;
  assign start_o        = start_r;
  assign busy_o         = (state_r != Idle);
  assign cfg_complete_o = (state_r != RunPending);

endmodule

// File: tb/tb_redmule_cfg_slave.sv
// Scoreboard bench for redmule_cfg_slave: the driver updates a job-level model
// and queues expected responses / start events; monitors compare on r_valid and start_o.
module tb_redmule_cfg_slave;

  localparam int N = 6;
  typedef logic [N*32-1:0] bank_t;
  typedef struct packed {logic [7:0] id; logic [31:0] data;} resp_t;

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, done = 1'b0;
  bank_t cfg_o;
  logic start_o, busy_o, cfg_complete_o;

  hwpe_ctrl_intf_periph #(.ID_WIDTH(8)) periph_if ();

  always #5 clk = ~clk;

  redmule_cfg_slave #(.SysDataWidth(32), .NumCfgRegs(N), .CfgBase(8'h40), .IdWidth(8)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .clear_i        (clear),
    .periph         (periph_if.slave),
    .engine_done_i  (done),
    .cfg_o          (cfg_o),
    .start_o        (start_o),
    .busy_o         (busy_o),
    .cfg_complete_o (cfg_complete_o)
  );

  int n_checks = 0, n_pass = 0;

  // Reference model: job-level view of the target.
  bank_t m_shadow = '0, m_active = '0;
  bit    m_running = 1'b0;
  bank_t m_pend[$];
  resp_t resp_q[$];
  bank_t start_q[$];

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    m_shadow  = '0;
    m_active  = '0;
    m_running = 1'b0;
    m_pend.delete();
  endtask

  task automatic model_start(input bank_t b);
    m_active = b;
    start_q.push_back(b);
  endtask

  // One clock cycle of stimulus plus model update.
  task automatic cycle(input logic rq, input logic wn, input logic [31:0] ad, input logic [31:0] dt,
                       input logic [3:0] b, input logic [7:0] id, input logic dn, input logic clr,
                       output logic granted);
    logic [5:0]  word;
    logic        is_trig, is_stat, is_cfg, exp_gnt, trig;
    int          idx;
    logic [31:0] val;
    @(negedge clk);
    periph_if.req = rq; periph_if.wen = wn; periph_if.add = ad; periph_if.data = dt;
    periph_if.be = b; periph_if.id = id; done = dn; clear = clr;
    #1;
    word    = ad[7:2];
    is_trig = (word == 6'd0);
    is_stat = (word == 6'd1);
    is_cfg  = (word >= 6'd16) && (int'(word) < 16 + N);
    idx     = int'(word) - 16;
    exp_gnt = rq && !(!wn && is_trig && m_pend.size() != 0);
    chk("gnt", periph_if.gnt, exp_gnt);
    chk("busy_o", busy_o, m_running);
    chk("cfg_complete_o", cfg_complete_o, m_pend.size() == 0);
    chk("cfg_o", cfg_o, m_active);
    granted = exp_gnt;
    if (clr) begin
      model_reset();
    end else begin
      if (exp_gnt) begin
        val = 32'd0;
        if (wn && is_stat) val = {30'd0, m_pend.size() != 0, m_running};
        else if (wn && is_cfg) val = m_shadow[idx*32 +: 32];
        resp_q.push_back('{id: id, data: val});
      end
      if (exp_gnt && !wn && is_cfg) begin
        for (int k = 0; k < 4; k++)
          if (b[k]) m_shadow[idx*32 + k*8 +: 8] = dt[k*8 +: 8];
      end
      trig = exp_gnt && !wn && is_trig;
      if (trig && dn && m_running && m_pend.size() == 0) begin
        model_start(m_shadow);
      end else begin
        if (dn && m_running) begin
          if (m_pend.size() != 0) model_start(m_pend.pop_front());
          else m_running = 1'b0;
        end
        if (trig) begin
          if (!m_running) begin
            m_running = 1'b1;
            model_start(m_shadow);
          end else begin
            m_pend.push_back(m_shadow);
          end
        end
      end
    end
    @(posedge clk);
  endtask

  logic g;
  task automatic wr(input logic [31:0] ad, input logic [31:0] dt, input logic [3:0] b, input logic dn);
    cycle(1'b1, 1'b0, ad, dt, b, 8'($urandom), dn, 1'b0, g);
  endtask
  task automatic rd(input logic [31:0] ad);
    cycle(1'b1, 1'b1, ad, 32'($urandom), 4'hF, 8'($urandom), 1'b0, 1'b0, g);
  endtask
  task automatic idle(input logic dn);
    cycle(1'b0, 1'b1, 32'd0, 32'd0, 4'h0, 8'd0, dn, 1'b0, g);
  endtask

  // Response monitor: every granted request answers exactly one cycle later.
  always @(negedge clk) begin : mon_resp
    resp_t e;
    if (periph_if.r_valid) begin
      if (resp_q.size() == 0) chk("unexpected_r_valid", 1'b1, 1'b0);
      else begin
        e = resp_q.pop_front();
        chk("r_id", periph_if.r_id, e.id);
        chk("r_data", periph_if.r_data, e.data);
      end
    end else if (resp_q.size() != 0) begin
      chk("r_valid_latency", 1'b0, 1'b1);
      void'(resp_q.pop_front());
    end
  end

  // Start monitor: start_o must coincide with the expected new active bank.
  always @(negedge clk) begin : mon_start
    bank_t e;
    if (start_o) begin
      if (start_q.size() == 0) chk("unexpected_start_o", 1'b1, 1'b0);
      else begin
        e = start_q.pop_front();
        chk("start_cfg_o", cfg_o, e);
        chk("start_busy_o", busy_o, 1'b1);
      end
    end else if (start_q.size() != 0) begin
      chk("start_o_missing", 1'b0, 1'b1);
      void'(start_q.pop_front());
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    bank_t job1;
    logic hold, rq, wn, dn, clr;
    logic [31:0] ad, dt;
    logic [3:0] b;
    logic [7:0] id;
    int sel;
    job1 = {32'h66, 32'h55, 32'h44, 32'h33, 32'h22, 32'h11};
    periph_if.req = 1'b0; periph_if.wen = 1'b1; periph_if.add = '0;
    periph_if.data = '0; periph_if.be = '0; periph_if.id = '0;
    #12;
    chk("rst_r_valid", periph_if.r_valid, 1'b0);
    chk("rst_r_data", periph_if.r_data, 32'd0);
    chk("rst_r_id", periph_if.r_id, 8'd0);
    chk("rst_start_o", start_o, 1'b0);
    chk("rst_busy_o", busy_o, 1'b0);
    chk("rst_cfg_complete_o", cfg_complete_o, 1'b1);
    chk("rst_cfg_o", cfg_o, '0);
    #10 rst_n = 1'b1;
    idle(1'b0);

    // First job: fill six words and trigger.
    for (int i = 0; i < N; i++) wr(32'h40 + 32'(4*i), 32'h11 * 32'(i+1), 4'hF, 1'b0);
    rd(32'h04);
    wr(32'h00, 32'hDEAD_BEEF, 4'hF, 1'b0);
    idle(1'b0);
    #1 chk("cfg_o_job1", cfg_o, job1);

    // Byte-lane masked write then read back.
    rd(32'h04);
    wr(32'h4C, 32'h0, 4'hF, 1'b0);
    wr(32'h4C, 32'hAABBCCDD, 4'b0101, 1'b0);
    rd(32'h4C);

    // Queue one job, stall a second, then release with done.
    wr(32'h00, 32'h1, 4'hF, 1'b0);
    rd(32'h04);
    wr(32'h44, 32'h12345678, 4'hF, 1'b0);
    wr(32'h00, 32'h2, 4'hF, 1'b0);
    wr(32'h00, 32'h2, 4'hF, 1'b0);
    wr(32'h00, 32'h2, 4'hF, 1'b1);
    wr(32'h00, 32'h2, 4'hF, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    rd(32'h04);

    // Done and trigger together with an empty slot.
    wr(32'h00, 32'h3, 4'hF, 1'b0);
    wr(32'h50, 32'hCAFE_F00D, 4'hF, 1'b0);
    wr(32'h00, 32'h4, 4'hF, 1'b1);
    idle(1'b0);
    rd(32'h04);
    idle(1'b1);

    // Unmapped address.
    rd(32'h90);
    wr(32'h90, 32'hFFFF_FFFF, 4'hF, 1'b0);
    rd(32'h04);

    // Reset while a job is pending.
    wr(32'h00, 32'h5, 4'hF, 1'b0);
    wr(32'h00, 32'h6, 4'hF, 1'b0);
    idle(1'b0);
    idle(1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy_o", busy_o, 1'b0);
    chk("arst_cfg_o", cfg_o, '0);
    chk("arst_cfg_complete_o", cfg_complete_o, 1'b1);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) idle(1'b1);
    rd(32'h04);

    // Randomized traffic with occasional done pulses and clears.
    hold = 1'b0; rq = 1'b0; wn = 1'b1; ad = '0; dt = '0; b = '0; id = '0;
    for (int k = 0; k < 400; k++) begin
      if (!hold) begin
        sel = int'($urandom_range(0, 7));
        case (sel)
          0, 1:    ad = 32'h00;
          2:       ad = 32'h04;
          3, 4, 5: ad = 32'h40 + 32'(4 * $urandom_range(0, N-1));
          6:       ad = 32'h90;
          default: ad = 32'($urandom_range(0, 255));
        endcase
        ad = {ad[31:2], 2'($urandom)};
        rq = ($urandom % 4) != 0;
        wn = 1'($urandom);
        dt = $urandom;
        b  = 4'($urandom);
        id = 8'($urandom);
      end
      dn  = ($urandom % 6) == 0;
      clr = ($urandom % 97) == 0;
      if (clr) rq = 1'b0;
      cycle(rq, wn, ad, dt, b, id, dn, clr, g);
      hold = rq && !g;
    end
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
    chk("start_q_drained", 32'(start_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
